// File: rtl/output_layer_argmax.sv
// Collects one sigmoid byte per output neuron, then scans the captured set
// one entry per cycle and reports the argmax class and its score.
module output_layer_argmax #(
    parameter int N_CLASSES = 10,
    parameter int IDX_W     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [N_CLASSES-1:0]   sig_ready,
    input  logic [8*N_CLASSES-1:0] sig_data,
    output logic [IDX_W-1:0]       class_idx,
    output logic [7:0]             class_score,
    output logic                   result_valid,
    output logic                   busy,
    output logic                   overrun
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SCAN    = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

    state_t               state;
    logic [N_CLASSES-1:0] captured;
    logic [N_CLASSES-1:0] captured_next;
    logic [7:0]           cap_regs [N_CLASSES];
    logic [IDX_W-1:0]     scan_idx;
    logic [IDX_W-1:0]     best_idx;
    logic [7:0]           best_val;
    logic [7:0]           scan_val;
    logic [IDX_W-1:0]     cand_idx;
    logic [7:0]           cand_val;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        captured_next = captured | sig_ready;
        scan_val      = cap_regs[scan_idx];
        cand_idx      = best_idx;
        cand_val      = best_val;
        if (scan_val > best_val) begin
            cand_idx = scan_idx;
            cand_val = scan_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= COLLECT;
            captured     <= '0;
            scan_idx     <= '0;
            best_idx     <= '0;
            best_val     <= '0;
            class_idx    <= '0;
            class_score  <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < N_CLASSES; i++) begin
                cap_regs[i] <= '0;
            end
        end else begin
            result_valid <= 1'b0;
            if (clear) begin
                // Abandons any scan; the last result and overrun stay visible.
                state    <= COLLECT;
                captured <= '0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    COLLECT: begin
                        for (int i = 0; i < N_CLASSES; i++) begin
                            if (sig_ready[i] && !captured[i]) begin
                                cap_regs[i] <= sig_data[8*i +: 8];
                            end
                        end
                        if (|(sig_ready & captured)) begin
                            overrun <= 1'b1;
                        end
                        captured <= captured_next;
                        if (&captured_next) begin
                            state    <= SCAN;
                            scan_idx <= '0;
                            best_idx <= '0;
                            best_val <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    SCAN: begin
                        if (|sig_ready) begin
                            overrun <= 1'b1;
                        end
                        best_idx <= cand_idx;
                        best_val <= cand_val;
                        if (scan_idx == LAST_IDX) begin
                            class_idx    <= cand_idx;
                            class_score  <= cand_val;
                            result_valid <= 1'b1;
                            busy         <= 1'b0;
                            state        <= DONE;
                        end else begin
                            scan_idx <= scan_idx + 1'b1;
                        end
                    end
                    DONE: begin
                        if (|sig_ready) begin
                            overrun <= 1'b1;
                        end
                    end
                    default: begin
                        state <= COLLECT;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/output_layer_argmax.md
Name: output_layer_argmax

Overview:
- Downstream stage of the output-layer neurons. Collects one 8-bit sigmoid activation per output neuron, each presented with a one-cycle ready pulse.
- Once all N activations are captured, scans them sequentially and reports the winning class index (argmax) and its score.
- The result drives the digit display/readout logic.

Parameters:
- N_CLASSES, 10, number of output neurons/classes collected.
- IDX_W, 4, width of class index; must satisfy 2^IDX_W >= N_CLASSES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  one-cycle pulse; discards captured data and rearms for a new image.
- sig_ready  input  N_CLASSES  bit i pulses for one cycle when neuron i's sigmoid_out is valid.
- sig_data  input  8*N_CLASSES  neuron i's unsigned sigmoid value at bits [8i+7:8i].
- class_idx  output  IDX_W  winning class index.
- class_score  output  8  sigmoid value of the winner.
- result_valid  output  1  one-cycle pulse when class_idx/class_score are updated.
- busy  output  1  high in SCAN state.
- overrun  output  1  sticky; a neuron reported twice, or reported outside COLLECT.

Behaviour:
- Reset values: class_idx=0, class_score=0, result_valid=0, busy=0, overrun=0. Internal state: captured bitmap=0, capture regs=0, state=COLLECT.
- States are COLLECT, SCAN and DONE.

COLLECT:
- Each cycle, for every i with sig_ready[i]=1 and captured[i]=0: capture sig_data byte i into reg i and set captured[i].
- Multiple neurons may report in the same cycle; all are captured.
- sig_ready[i]=1 with captured[i]=1: data is ignored (first value kept) and overrun is set.
- When the captures on an edge make captured all-ones, that same edge moves to SCAN and resets scan index=0, best_val=0, best_idx=0.

SCAN:
- busy=1. Examines one entry per cycle, i = 0..N_CLASSES-1.
- best is updated only if reg[i] > best_val (strictly greater). Ties therefore resolve to the lowest index; an all-zero set yields index 0, score 0.
- On the edge processing i=N_CLASSES-1: register class_idx/class_score from the final compare (including entry N-1), assert result_valid for the next cycle only, and move to DONE.
- Any sig_ready bit high during SCAN or DONE is ignored and sets overrun.

DONE:
- class_idx and class_score hold until the next result. busy=0.

Latency:
- If the last outstanding capture is sampled at edge k, SCAN runs during cycles k+1..k+N_CLASSES, and result_valid is high in the cycle after edge k+N_CLASSES.
- For N=10, that is the 11th cycle after the capturing edge.

clear:
- Legal in any state, including mid-SCAN.
- Next state is COLLECT, captured=0, and any in-progress scan is abandoned with no result_valid.
- class_idx, class_score and overrun are retained. overrun is cleared only by reset.
- If clear and sig_ready occur in the same cycle, clear wins and that sig_ready is dropped.

reset:
- Overrides everything in any state, including mid-SCAN.
- Returns all outputs and state to the reset values above.

Arithmetic:
- Unsigned 8-bit compare only; no arithmetic on captured data.
- Scan index counter has IDX_W bits and never exceeds N_CLASSES-1.

Test Plan:
- Sequential reports: neurons 0..9 report one per cycle with values 10,20,...,100 → after last capture, busy for 10 cycles, then one result_valid pulse with class_idx=9, class_score=100, overrun=0.
- Simultaneous reports: all 10 neurons report in the same cycle, value 200 on neuron 3 and 50 elsewhere → class_idx=3, class_score=200; result_valid exactly 11 cycles after the capturing edge.
- Tie: neurons 2 and 7 both 0xF0, others 0x10, any report order → class_idx=2, class_score=0xF0.
- Duplicate report: neuron 5 reports 0x80, then reports 0xFF again before collection completes, others 0x40 → overrun=1, winner class_idx=5 with score 0x80 (first value kept).
- Mid-operation clear: complete collection, pulse clear in the 4th SCAN cycle → no result_valid, busy=0 the next cycle. A new full set with neuron 1=0x99 as maximum → class_idx=1, class_score=0x99.
- Mid-operation reset: reset asserted during SCAN with a prior result held → all outputs 0 on the next cycle. A subsequent full collection (all values 0) → class_idx=0, class_score=0, result_valid pulses once.
